// File: rtl/spi_slave_burst.sv
// spi_slave_burst: SPI slave that turns cmd+word frames into rx_data pulses and shifts RAM read data out on MISO,
// with optional multi-word bursts per SS_n frame and a sticky tx_valid timeout flag.
module spi_slave_burst #(
  parameter int DATA_W     = 8,
  parameter bit BURST_EN   = 1'b1,
  parameter int TX_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              err
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam int WW = TX_TIMEOUT > 0 ? $clog2(TX_TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, CMD, SHIFT_IN, WAIT_TX, SHIFT_OUT, DRAIN} state_t;
  state_t            state;
  logic              ss_q;
  logic [1:0]        cmd;
  logic [CW-1:0]     cnt;
  logic [WW-1:0]     wcnt;
  logic [DATA_W-1:0] sr, txsr, sr_nx;
  logic              last;
  assign sr_nx = DATA_W'({sr, MOSI});
  assign last  = cnt == CW'(DATA_W - 1);
  // ss_q gates frame start so a frame only begins on a sampled high->low SS_n transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ss_q     <= 1'b0;
      cmd      <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      sr       <= '0;
      txsr     <= '0;
      MISO     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      ss_q     <= SS_n;
      rx_valid <= 1'b0;
      MISO     <= 1'b0;
      if (SS_n && state != IDLE) begin
        state <= IDLE;
        cnt   <= '0;
        wcnt  <= '0;
      end else begin
        case (state)
          IDLE: if (!SS_n && ss_q) begin
            state <= CMD;
            err   <= 1'b0;
            cnt   <= '0;
          end
          CMD: begin
            cmd <= {cmd[0], MOSI};
            cnt <= cnt[0] ? '0 : cnt + 1'b1;
            if (cnt[0]) state <= SHIFT_IN;
          end
          SHIFT_IN: begin
            sr  <= sr_nx;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
              rx_valid <= 1'b1;
              rx_data  <= {cmd, sr_nx};
              wcnt     <= '0;
              state    <= cmd == 2'b11 ? WAIT_TX : (cmd == 2'b01 && BURST_EN) ? SHIFT_IN : DRAIN;
            end
          end
          WAIT_TX: if (tx_valid) begin
            txsr  <= tx_data << 1;
            MISO  <= tx_data[DATA_W-1];
            cnt   <= '0;
            wcnt  <= '0;
            state <= SHIFT_OUT;
          end else if (TX_TIMEOUT > 0 && wcnt == WW'(TX_TIMEOUT - 1)) begin
            err   <= 1'b1;
            wcnt  <= '0;
            state <= DRAIN;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
          SHIFT_OUT: if (last) begin
            cnt   <= '0;
            state <= BURST_EN ? WAIT_TX : DRAIN;
            if (BURST_EN) begin
              rx_valid <= 1'b1;
              rx_data  <= {2'b11, {DATA_W{1'b0}}};
            end
          end else begin
            MISO <= txsr[DATA_W-1];
            txsr <= txsr << 1;
            cnt  <= cnt + 1'b1;
          end
          DRAIN: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_burst.sv
// tb_spi_slave_burst: directed checks of framing, bursts, read shift-out, timeout and reset for spi_slave_burst.
module tb_spi_slave_burst;
  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid, err;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
  int         checks = 0;
  int         errors = 0;
  spi_slave_burst #(.DATA_W(8), .BURST_EN(1'b1), .TX_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = v[i];
      tick();
    end
  endtask
  task automatic start();
    SS_n = 1'b1;
    tick();
    SS_n = 1'b0;
    tick();
  endtask
  logic [7:0] c3;
  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    c3 = 8'hC3;
    tick(); tick();
    chk("rst_miso", MISO, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    start();
    send({2'b00, 8'hA5}, 10);
    chk("wa_rxv", rx_valid, 1);
    chk("wa_rxd", rx_data, 10'h0A5);
    send(10'h3FF, 6);
    chk("wa_drain_rxv", rx_valid, 0);
    chk("wa_drain_miso", MISO, 0);
    start();
    send({2'b01, 8'h12}, 10);
    chk("b1_rxv", rx_valid, 1);
    chk("b1_rxd", rx_data, 10'h112);
    send(10'h034, 1);
    chk("b2_mid_rxv", rx_valid, 0);
    send(10'h034, 7);
    chk("b2_rxv", rx_valid, 1);
    chk("b2_rxd", rx_data, 10'h134);
    send(10'h056, 8);
    chk("b3_rxv", rx_valid, 1);
    chk("b3_rxd", rx_data, 10'h156);
    SS_n = 1'b1;
    tick();
    chk("b_end_rxv", rx_valid, 0);
    chk("b_end_rxd", rx_data, 10'h156);
    start();
    send({2'b11, 8'h00}, 10);
    chk("rd_rxv", rx_valid, 1);
    chk("rd_rxd", rx_data, 10'h300);
    tx_data = 8'hC3;
    tick(); tick();
    chk("rd_wait_miso", MISO, 0);
    tx_valid = 1'b1;
    tick();
    chk("rd_bit7", MISO, 1);
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk($sformatf("rd_bit%0d", i), MISO, c3[i]);
    end
    tick();
    chk("rd_end_miso", MISO, 0);
    chk("rd_next_rxv", rx_valid, 1);
    chk("rd_next_rxd", rx_data, 10'h300);
    start();
    send({2'b11, 8'h5A}, 10);
    chk("to_rxd", rx_data, 10'h35A);
    tick(); tick(); tick();
    chk("to_err_early", err, 0);
    tick();
    chk("to_err", err, 1);
    chk("to_miso", MISO, 0);
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    chk("to_txv_ignored", MISO, 0);
    tx_valid = 1'b0;
    SS_n = 1'b1;
    tick();
    chk("to_err_sticky", err, 1);
    SS_n = 1'b0;
    tick();
    chk("to_err_clear", err, 0);
    send({2'b01, 8'hFF}, 7);
    SS_n = 1'b1;
    tick();
    chk("part_rxv", rx_valid, 0);
    chk("part_rxd", rx_data, 10'h35A);
    tick();
    chk("part_idle_rxv", rx_valid, 0);
    SS_n = 1'b0;
    tick();
    send({2'b01, 8'hFF}, 9);
    SS_n = 1'b1;
    MOSI = 1'b1;
    tick();
    chk("prio_rxv", rx_valid, 0);
    chk("prio_rxd", rx_data, 10'h35A);
    start();
    send({2'b00, 8'h3C}, 10);
    chk("after_rxd", rx_data, 10'h03C);
    start();
    send({2'b11, 8'h00}, 10);
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    chk("rs_miso_pre", MISO, 1);
    tx_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rs_miso", MISO, 0);
    chk("rs_rxv", rx_valid, 0);
    chk("rs_err", err, 0);
    chk("rs_rxd", rx_data, 0);
    tick();
    rst_n = 1'b1;
    MOSI = 1'b1; tx_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("rs_hold", {rx_valid, MISO}, 2'b00);
    end
    tx_valid = 1'b0;
    start();
    send({2'b00, 8'h81}, 10);
    chk("rs_new_rxv", rx_valid, 1);
    chk("rs_new_rxd", rx_data, 10'h081);
    SS_n = 1'b1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
